// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter/sequencer in front of a word-write data memory.
// Adds RV32 byte/half/word sizing: loads are lane-aligned and extended, sub-word
// stores become read-modify-write. One transaction in flight at a time.
// Ports:
//   clk_i, reset_n                  clock (rising edge), async active-low reset
//   req*/we*/size*/uns*/addr*/wdata* per-port request (latched at accept)
//   ack*/err*/rdata*                per-port one-cycle completion response
//   mem_addr_o/mem_wdata_o/mem_we_o/mem_re_o/mem_rdata_i  memory side
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 6,
  parameter bit          PRIO_FIXED = 1'b0
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [1:0]  size0_i,
  input  logic [1:0]  size1_i,
  input  logic        uns0_i,
  input  logic        uns1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_we_o,
  output logic        mem_re_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_e;

  state_e      state_q, state_d;
  logic        port_q, port_d;
  logic        last_q, last_d;   // 1 = port 1 was served last
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;

  logic        win;
  logic        win_we, win_uns, win_err;
  logic [1:0]  win_size;
  logic [31:0] win_addr, win_wdata;
  logic [4:0]  sh;
  logic [31:0] mask, merged, lane, load_val;

  // Arbitration and request-field mux
  always_comb begin
    if (req0_i && req1_i) win = PRIO_FIXED ? 1'b0 : ~last_q;
    else                  win = ~req0_i;
    win_we    = win ? we1_i    : we0_i;
    win_size  = win ? size1_i  : size0_i;
    win_uns   = win ? uns1_i   : uns0_i;
    win_addr  = win ? addr1_i  : addr0_i;
    win_wdata = win ? wdata1_i : wdata0_i;
    win_err   = (win_size == 2'b11)
             || (win_size == 2'b01 && win_addr[0])
             || (win_size == 2'b10 && win_addr[1:0] != 2'b00)
             || ((win_addr >> ADDR_W) != '0);
  end

  // Lane handling: shift by the byte offset for both store merge and load align
  always_comb begin
    sh     = {addr_q[1:0], 3'b000};
    mask   = ((size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    merged = (word_q & ~mask) | ((wdata_q << sh) & mask);
    lane   = word_q >> sh;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, lane[7:0]}  : {{24{lane[7]}},  lane[7:0]};
      2'b01:   load_val = uns_q ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    last_d      = last_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    word_d      = word_q;
    ack0_o      = 1'b0;
    ack1_o      = 1'b0;
    err0_o      = 1'b0;
    err1_o      = 1'b0;
    rdata0_o    = '0;
    rdata1_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    mem_re_o    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          port_d  = win;
          last_d  = win;
          we_d    = win_we;
          size_d  = win_size;
          uns_d   = win_uns;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          err_d   = win_err;
          if (win_err)                          state_d = RESP;
          else if (win_we && win_size == 2'b10) state_d = WR;
          else                                  state_d = RD;
        end
      end
      RD: begin
        mem_re_o   = 1'b1;
        mem_addr_o = {addr_q[31:2], 2'b00};
        word_d     = mem_rdata_i;
        state_d    = we_q ? WR : RESP;
      end
      WR: begin
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_q[31:2], 2'b00};
        mem_wdata_o = (size_q == 2'b10) ? wdata_q : merged;
        state_d     = RESP;
      end
      RESP: begin
        if (port_q) begin
          ack1_o   = 1'b1;
          err1_o   = err_q;
          rdata1_o = (!err_q && !we_q) ? load_val : '0;
        end else begin
          ack0_o   = 1'b1;
          err0_o   = err_q;
          rdata0_o = (!err_q && !we_q) ? load_val : '0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      last_q  <= last_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level reference model predicts the
// full per-cycle output schedule of each accepted request; a negedge process
// compares every output every cycle. Directed scenarios add literal checks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, uns0 = 0, uns1 = 0;
  logic [1:0]  size0 = 0, size1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, err0, err1, mem_we, mem_re;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

  // fixed-priority instance
  logic        f_req0 = 0, f_req1 = 0;
  logic        f_ack0, f_ack1, f_err0, f_err1, f_mem_we, f_mem_re;
  logic [31:0] f_rdata0, f_rdata1, f_mem_addr, f_mem_wdata;
  logic [31:0] f_mem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(6), .PRIO_FIXED(1'b0)) dut (
    .clk_i(clk), .reset_n(reset_n),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .size0_i(size0), .size1_i(size1), .uns0_i(uns0), .uns1_i(uns1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .err0_o(err0), .err1_o(err1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
    .mem_re_o(mem_re), .mem_rdata_i(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(6), .PRIO_FIXED(1'b1)) dut_fx (
    .clk_i(clk), .reset_n(reset_n),
    .req0_i(f_req0), .req1_i(f_req1), .we0_i(1'b0), .we1_i(1'b0),
    .size0_i(2'b10), .size1_i(2'b10), .uns0_i(1'b0), .uns1_i(1'b0),
    .addr0_i(32'h0), .addr1_i(32'h4), .wdata0_i(32'h0), .wdata1_i(32'h0),
    .ack0_o(f_ack0), .ack1_o(f_ack1), .err0_o(f_err0), .err1_o(f_err1),
    .rdata0_o(f_rdata0), .rdata1_o(f_rdata1),
    .mem_addr_o(f_mem_addr), .mem_wdata_o(f_mem_wdata), .mem_we_o(f_mem_we),
    .mem_re_o(f_mem_re), .mem_rdata_i(f_mem_rdata)
  );

  // The memory device itself (not reset)
  logic [31:0] mem [16];
  initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  assign mem_rdata = mem_re ? mem[mem_addr[5:2]] : 32'h0;
  always @(posedge clk) if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        ack0, ack1, err0, err1, mem_we, mem_re;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
  } exp_t;

  exp_t        sched[$];
  logic [31:0] ref_mem [16];
  bit          last_p1 = 1'b1;
  initial for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

  function automatic void predict(input bit p, input logic w, input logic [1:0] sz,
                                  input logic u, input logic [31:0] a, input logic [31:0] wd);
    exp_t        e, r;
    bit          bad;
    int unsigned off;
    logic [31:0] wa, word, val, m;
    bad = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0) || (a >= 64);
    wa  = a - (a % 4);
    off = 8 * (a % 4);
    r   = '0;
    if (p) r.ack1 = 1; else r.ack0 = 1;
    if (bad) begin
      if (p) r.err1 = 1; else r.err0 = 1;
    end else begin
      word = ref_mem[a[5:2]];
      if (!(w && sz == 2)) begin
        e = '0; e.mem_re = 1; e.mem_addr = wa; sched.push_back(e);
      end
      if (w) begin
        m = (sz == 0 ? 32'hFF : (sz == 1 ? 32'hFFFF : 32'hFFFF_FFFF)) << off;
        e = '0; e.mem_we = 1; e.mem_addr = wa;
        e.mem_wdata = (word & ~m) | ((wd << off) & m);
        sched.push_back(e);
      end else begin
        val = word >> off;
        if (sz == 0) val = (!u && val[7])  ? (val | 32'hFFFF_FF00) : (val & 32'hFF);
        if (sz == 1) val = (!u && val[15]) ? (val | 32'hFFFF_0000) : (val & 32'hFFFF);
        if (p) r.rdata1 = val; else r.rdata0 = val;
      end
    end
    sched.push_back(r);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    bit   p;
    e = '0;
    if (!reset_n) begin
      sched.delete();
      last_p1 = 1'b1;
    end else if (sched.size() != 0) begin
      e = sched.pop_front();
    end else if (req0 || req1) begin
      p = (req0 && req1) ? !last_p1 : req1;
      last_p1 = p;
      if (p) predict(1'b1, we1, size1, uns1, addr1, wdata1);
      else   predict(1'b0, we0, size0, uns0, addr0, wdata0);
    end
    chk("ack0", ack0, e.ack0);
    chk("ack1", ack1, e.ack1);
    chk("err0", err0, e.err0);
    chk("err1", err1, e.err1);
    chk("rdata0", rdata0, e.rdata0);
    chk("rdata1", rdata1, e.rdata1);
    chk("mem_we", mem_we, e.mem_we);
    chk("mem_re", mem_re, e.mem_re);
    chk("mem_addr", mem_addr, e.mem_addr);
    chk("mem_wdata", mem_wdata, e.mem_wdata);
    if (reset_n && e.mem_we) ref_mem[e.mem_addr[5:2]] = e.mem_wdata;
  end

  // ---------------- stimulus ----------------
  task automatic do_req(input bit p, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_err, input string nm);
    int          n;
    bit          got;
    logic [31:0] rd;
    logic        er;
    @(posedge clk); #1;
    if (p) begin req1 = 1; we1 = w; size1 = sz; uns1 = u; addr1 = a; wdata1 = wd; end
    else   begin req0 = 1; we0 = w; size0 = sz; uns0 = u; addr0 = a; wdata0 = wd; end
    got = 0; n = 0; rd = '0; er = 0;
    while (!got && n < 10) begin
      @(negedge clk);
      if ((!p && ack0) || (p && ack1)) begin
        got = 1; rd = p ? rdata1 : rdata0; er = p ? err1 : err0;
      end else n++;
    end
    if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({nm, "_lat"}, n, exp_lat);
      chk({nm, "_rdata"}, rd, exp_rd);
      chk({nm, "_err"}, {31'd0, er}, {31'd0, exp_err});
    end
    @(posedge clk); #1;
    if (p) req1 = 0; else req0 = 0;
  endtask

  task automatic rand_fields(output logic w, output logic [1:0] sz, output logic u,
                             output logic [31:0] a, output logic [31:0] wd);
    w  = 1'($urandom_range(0, 1));
    sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    u  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0:       a = $urandom;
      1:       a = 32'($urandom_range(64, 80));
      default: a = 32'($urandom_range(0, 63));
    endcase
    if ($urandom_range(0, 3) != 0) begin
      if (sz == 2'b10) a[1:0] = 2'b00;
      else if (sz == 2'b01) a[0] = 1'b0;
    end
    wd = $urandom;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          order[$];
    int          a0c, a1c, cnt0, cnt1;
    logic        s0, s1;
    repeat (3) @(negedge clk);
    chk("rst_ack0", ack0, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk); #1 reset_n = 1;

    // word store/load, sub-word RMW, extension, errors
    do_req(0, 1, 2'b10, 0, 32'h08, 32'hDEADBEEF, 2, 32'h0, 0, "sw08");
    do_req(0, 0, 2'b10, 0, 32'h08, 32'h0, 2, 32'hDEADBEEF, 0, "lw08");
    do_req(0, 1, 2'b00, 0, 32'h09, 32'h000000A5, 3, 32'h0, 0, "sb09");
    chk("mem08_after_sb", mem[2], 32'hDEADA5EF);
    do_req(0, 0, 2'b00, 0, 32'h09, 32'h0, 2, 32'hFFFFFFA5, 0, "lb09");
    do_req(0, 0, 2'b00, 1, 32'h09, 32'h0, 2, 32'h000000A5, 0, "lbu09");
    do_req(0, 0, 2'b01, 0, 32'h0A, 32'h0, 2, 32'hFFFFDEAD, 0, "lh0A");
    do_req(0, 0, 2'b01, 1, 32'h0A, 32'h0, 2, 32'h0000DEAD, 0, "lhu0A");
    do_req(0, 0, 2'b01, 0, 32'h0B, 32'h0, 1, 32'h0, 1, "lh0B");
    do_req(0, 0, 2'b10, 0, 32'h40, 32'h0, 1, 32'h0, 1, "lw40");
    do_req(1, 1, 2'b11, 0, 32'h00, 32'h5, 1, 32'h0, 1, "bad_size");

    // reset in the RD phase of a half store
    do_req(0, 1, 2'b10, 0, 32'h04, 32'h11223344, 2, 32'h0, 0, "sw04");
    @(posedge clk); #1;
    req1 = 1; we1 = 1; size1 = 2'b01; uns1 = 0; addr1 = 32'h04; wdata1 = 32'h1234;
    @(posedge clk); #1;
    chk("in_rd_before_rst", mem_re, 1);
    reset_n = 0;
    @(negedge clk);
    chk("rst_mid_ack1", ack1, 0);
    chk("rst_mid_mem_re", mem_re, 0);
    req1 = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (3) @(negedge clk);
    chk("mem04_kept", mem[1], 32'h11223344);

    // round-robin with both requesting continuously
    @(posedge clk); #1;
    req0 = 1; we0 = 0; size0 = 2'b10; addr0 = 32'h08;
    req1 = 1; we1 = 0; size1 = 2'b10; addr1 = 32'h04;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
    end
    @(posedge clk); #1 req0 = 0; req1 = 0;
    chk("rr_count", order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) chk($sformatf("rr_order%0d", i), order[i], i % 2);

    // port 0 drops req after accept, port 1 waiting
    @(posedge clk); #1;
    req0 = 1; we0 = 0; size0 = 2'b10; addr0 = 32'h08;
    @(posedge clk); #1;
    req0 = 0;
    req1 = 1; we1 = 0; size1 = 2'b10; addr1 = 32'h04;
    a0c = -1; a1c = -1;
    for (int c = 1; c < 12 && a1c < 0; c++) begin
      @(negedge clk);
      if (ack0) begin a0c = c; chk("drop_rdata0", rdata0, 32'hDEADA5EF); end
      if (ack1) begin a1c = c; chk("pend_rdata1", rdata1, 32'h11223344); end
    end
    @(posedge clk); #1 req1 = 0;
    chk("drop_ack0_cycle", a0c, 2);
    chk("pend_ack1_cycle", a1c, 5);

    // fixed priority instance
    @(posedge clk); #1 f_req0 = 1; f_req1 = 1;
    cnt0 = 0; cnt1 = 0;
    repeat (30) begin
      @(negedge clk);
      if (f_ack0) cnt0++;
      if (f_ack1) cnt1++;
    end
    @(posedge clk); #1 f_req0 = 0; f_req1 = 0;
    chk("fx_p0_acks", cnt0, 10);
    chk("fx_p1_acks", cnt1, 0);

    // randomized traffic
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk); s0 = ack0; s1 = ack1;
      @(posedge clk); #1;
      if (req0 && s0) begin
        req0 = 1'($urandom_range(0, 1));
        if (req0) rand_fields(we0, size0, uns0, addr0, wdata0);
      end else if (req0 && $urandom_range(0, 15) == 0) req0 = 0;
      else if (!req0 && $urandom_range(0, 2) == 0) begin
        req0 = 1; rand_fields(we0, size0, uns0, addr0, wdata0);
      end else if (req0 && $urandom_range(0, 3) == 0) wdata0 = $urandom;
      if (req1 && s1) begin
        req1 = 1'($urandom_range(0, 1));
        if (req1) rand_fields(we1, size1, uns1, addr1, wdata1);
      end else if (req1 && $urandom_range(0, 15) == 0) req1 = 0;
      else if (!req1 && $urandom_range(0, 2) == 0) begin
        req1 = 1; rand_fields(we1, size1, uns1, addr1, wdata1);
      end else if (req1 && $urandom_range(0, 3) == 0) addr1 = 32'($urandom_range(0, 63));
    end
    req0 = 0; req1 = 0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 16; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
